// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Covers load-use and ID-stage branch operand hazards; counts stalls/flushes.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             BranchTaken,
  input  logic             Jump,
  input  logic             ID_Ex_MemRead,
  input  logic             ID_Ex_RegWrite,
  input  logic [4:0]       ID_Ex_WriteReg,
  input  logic             Ex_Mem_MemRead,
  input  logic [4:0]       Ex_Mem_WriteReg,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_Ex_Bubble,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [1:0]       rem_q, rem_d;
  logic [1:0]       need;
  logic             ex_match, mem_match;
  logic             run, stall, flush;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // $0 is hardwired, so it never produces a dependency
  assign ex_match = (ID_Ex_WriteReg != 5'd0) &&
                    ((ID_Ex_WriteReg == ID_Rs) ||
                     (ID_UsesRt && (ID_Ex_WriteReg == ID_Rt)));

  assign mem_match = (Ex_Mem_WriteReg != 5'd0) &&
                     ((Ex_Mem_WriteReg == ID_Rs) ||
                      (ID_UsesRt && (Ex_Mem_WriteReg == ID_Rt)));

  always_comb begin
    need = 2'd0;
    if (ID_Branch && ID_Ex_RegWrite && !ID_Ex_MemRead && ex_match)
      need = 2'd1;
    if (ID_Branch && Ex_Mem_MemRead && mem_match)
      need = 2'd1;
    if (ID_Ex_MemRead && ex_match)
      need = ID_Branch ? 2'd2 : 2'd1;
  end

  assign run   = (rem_q == 2'd0);
  assign stall = run ? (need != 2'd0) : 1'b1;
  assign flush = !stall && (BranchTaken || Jump);

  always_comb begin
    rem_d = 2'd0;
    if (run) begin
      if (need != 2'd0)
        rem_d = need - 2'd1;
    end else begin
      rem_d = rem_q - 2'd1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall && !(&stall_q))
      stall_d = stall_q + 1'b1;
    if (flush && !(&flush_q))
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      rem_q   <= rem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // reset overrides the controls combinationally so a stall aborts at once
  assign PCWrite      = rst | !stall;
  assign IF_ID_Write  = rst | !stall;
  assign ID_Ex_Bubble = !rst & stall;
  assign IF_ID_Flush  = !rst & flush;

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and flush controller for the five-stage MIPS pipeline, the complement of the forwarding logic. Forwarding resolves RAW hazards by steering data. This block handles the hazards forwarding cannot cover: load-use, and operands needed by the ID-stage branch comparator before they exist. It freezes PC and IF/ID, injects bubbles into ID/EX, flushes IF/ID on taken branches and jumps, and keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of the performance counters
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ID_Rs  in  5  rs field of the instruction in ID
- ID_Rt  in  5  rt field of the instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt (R-type, branch, sw)
- ID_Branch  in  1  ID instruction is beq/bne (compared in ID)
- BranchTaken  in  1  ID comparator result qualified by ID_Branch
- Jump  in  1  ID instruction is j/jal
- ID_Ex_MemRead  in  1  instruction in EX is a load
- ID_Ex_RegWrite  in  1  instruction in EX writes a register
- ID_Ex_WriteReg  in  5  destination of the instruction in EX
- Ex_Mem_MemRead  in  1  instruction in MEM is a load
- Ex_Mem_WriteReg  in  5  destination of the instruction in MEM
- PCWrite  out  1  1 = PC updates this cycle
- IF_ID_Write  out  1  1 = IF/ID register loads this cycle
- ID_Ex_Bubble  out  1  1 = ID/EX control fields cleared (NOP)
- IF_ID_Flush  out  1  1 = IF/ID synchronously cleared
- stall_cycles  out  CNT_W  total stall cycles, saturating
- flush_count  out  CNT_W  total flushes, saturating

## Operation
- Register $0 never causes a hazard. A match requires a destination ≠ 0.
- Rs match = dest==ID_Rs. Rt match = ID_UsesRt && dest==ID_Rt. "Match" means either.
- Required stall count `need` (0..2), evaluated only in state RUN. Take the maximum of all applicable terms:
  - ID_Ex_MemRead && match(ID_Ex_WriteReg) → 1 (load-use); → 2 if ID_Branch
  - ID_Branch && ID_Ex_RegWrite && !ID_Ex_MemRead && match(ID_Ex_WriteReg) → 1
  - ID_Branch && Ex_Mem_MemRead && match(Ex_Mem_WriteReg) → 1
- State is a 2-bit remaining-stall register `rem`. RUN means rem==0, STALL means rem>0.
- stall = (rem==0 && need>0) || rem>0.
- Next-state logic:
  - RUN: rem ← need−1 when need>0, otherwise stays 0.
  - STALL: rem ← rem−1. Hazards are not re-evaluated during STALL.
- While stall: PCWrite=0, IF_ID_Write=0, ID_Ex_Bubble=1, IF_ID_Flush=0.
- While not stall: PCWrite=1, IF_ID_Write=1, ID_Ex_Bubble=0, IF_ID_Flush=BranchTaken||Jump.
- A branch is resolved only in a non-stall cycle. BranchTaken presented during a stall is ignored.
- stall_cycles increments once per stall cycle. flush_count increments once per cycle with IF_ID_Flush=1. Both saturate at all-ones and do not wrap.

## Timing
- Control outputs are combinational from the current inputs and `rem`, valid within the same cycle. Registered state and counters update on the rising edge of clk.
- Stall lengths:
  - Load-use: exactly 1 bubble.
  - Load followed by a dependent branch: 2 consecutive bubbles.
  - ALU op followed by a dependent branch: 1 bubble.
- The branch resolves in the first non-stall cycle after the bubbles. Flush is asserted in that same cycle.
- Reset values: rem=0, stall_cycles=0, flush_count=0.
- While rst=1, outputs are forced to PCWrite=1, IF_ID_Write=1, ID_Ex_Bubble=0, IF_ID_Flush=0.
- An asserted rst in the middle of a 2-cycle stall aborts it immediately, asynchronously.
- After rst deasserts, the block starts in RUN.
- Hazard and taken branch in the same cycle: the stall wins and there is no flush that cycle.

## Test plan
- Load-use: EX lw $8, ID add $9,$8,$3 → one cycle with PCWrite=0, IF_ID_Write=0, ID_Ex_Bubble=1. Next cycle all normal. stall_cycles=1.
- Load then branch: EX lw $5, ID beq $5,$6 with BranchTaken=1 throughout → 2 bubble cycles with IF_ID_Flush=0, then a cycle with IF_ID_Flush=1. stall_cycles=2, flush_count=1.
- ALU then branch: EX add $4 (RegWrite=1), ID bne $1,$4 → 1 bubble. In a separate case, MEM lw $4 with ID bne $4,$2 → 1 bubble.
- $0 and rt-unused cases: EX lw $0 with ID add $1,$0,$0 → no stall. EX lw $7 with ID addi $2,$7-free rs and ID_UsesRt=0, ID_Rt=7 → no stall.
- Reset mid-stall: assert rst during the first bubble of a 2-cycle stall → outputs immediately return to reset values. After release, rem=0 and both counters read 0.
- Saturation: CNT_W=4 with 20 consecutive load-use stalls → stall_cycles holds at 15 and never wraps.
